freq_scale_ctrl: RTL and testbench
==================================

# freq_scale_ctrl

Occupancy-driven clock-frequency governor for the green router datapath. It samples the output-queue byte occupancy (`num_bytes_stay`) over fixed-length epochs and picks one of four core clock levels: 50, 62.5, 83 or 125 MHz. It negotiates each change with the clock-switch logic through a req/ack handshake, then drives the one-hot `choice_*` selects consumed by the clock mux. It sits beside the tick/register block, which supplies its configuration inputs and reads back its status.

## Interface
- `EPOCH_W`, default 32: width of the epoch length/counter.
- `ACK_TIMEOUT`, default 1024: cycles to wait for `sw_ack` before aborting a switch.
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high.
- `enable` in 1: governor on. When 0, the block forces the 125 MHz level.
- `num_bytes_stay` in 32: current queued bytes, sampled every cycle.
- `epoch_len` in EPOCH_W: epoch length in cycles. A value of 0 is treated as 1.
- `thresh_hi` in 32: peak occupancy above which the block goes to the top level.
- `thresh_lo` in 32: peak occupancy below which the block steps down one level.
- `hold_epochs` in 4: minimum number of full epochs after a committed change before the next step-down.
- `sw_req` out 1: switch request to the clock mux.
- `sw_level` out 2: requested level. Stable while `sw_req`=1.
- `sw_ack` in 1: clock mux has switched to `sw_level`.
- `level` out 2: committed level. 0=50, 1=62.5, 2=83, 3=125.
- `choice_50`, `choice_62_5`, `choice_83`, `choice_125` out 1 each: one-hot decode of `level`, registered.
- `switch_count` out 16: number of committed changes. Wraps at 0xFFFF→0.
- `ack_err` out 1: sticky flag, set on an ack timeout. Cleared only by reset.

## Operation
- Epoch counter `ep` runs from 0 to `max(epoch_len,1)-1`, then wraps. It runs in every FSM state.
- Peak register holds the maximum of `num_bytes_stay` over the epoch, including the sample taken on the epoch's last cycle. The peak reloads with the current sample on the first cycle of the next epoch.
- Hold counter `hc`:
  - Loaded with `hold_epochs` on each commit.
  - Decremented at each epoch end while nonzero.
- Decision at epoch end, evaluated only in IDLE and only with `enable`=1:
  - If `peak > thresh_hi` and `level < 3`: target = 3. This ignores `hc`.
  - Else if `peak < thresh_lo`, `level > 0` and `hc == 0`: target = `level - 1`.
  - Else: no action.
  - When both conditions hold (misconfigured thresholds), the up-switch wins.
- Enable override: in IDLE with `enable`=0 and `level != 3`, target = 3 immediately, without waiting for an epoch end.
- FSM states: IDLE, REQ, COMMIT.
  - IDLE → REQ on a target: `sw_req`←1, `sw_level`←target, timeout counter←0.
  - REQ → COMMIT when `sw_ack`=1.
  - REQ → IDLE when the timeout counter reaches ACK_TIMEOUT-1 without ack:
    - `sw_req`←0, `ack_err`←1.
    - `level` is unchanged.
    - `hc`←`hold_epochs`.
  - COMMIT → IDLE after one cycle:
    - `level`←`sw_level`, choice outputs updated.
    - `sw_req`←0.
    - `switch_count`++, `hc`←`hold_epochs`.
- While in REQ, `sw_level` is held even if `enable` or occupancy changes. Epoch-end decisions that occur outside IDLE are dropped, not queued.
- Reset values:
  - `level`=3 and `choice_125`=1; other choices 0.
  - `sw_req`=0 and `sw_level`=3.
  - `switch_count`=0, `ack_err`=0.
  - FSM in IDLE; `ep`, peak and `hc` all 0.
- Reset during REQ drops `sw_req` on the next edge. The clock mux must treat a request drop without ack as a cancel.

## Timing
- Epoch-end decision is registered: `sw_req` rises on the edge after the cycle where `ep == epoch_len-1`.
- `sw_ack` is sampled on clk. If ack is seen at edge N:
  - `level` and `choice_*` change at edge N+1.
  - `sw_req` falls at edge N+1.
  - `switch_count` increments at edge N+1.
- `sw_ack` asserted while `sw_req`=0 is ignored.
- Minimum spacing between two commits is 3 cycles. A further step-down additionally requires `hc` to expire.
- The `choice_*` outputs are always exactly one-hot, including during reset and switching.
- Equality with a threshold never triggers a change: comparisons are strict and unsigned.

## Test plan
- Scale-down chain: `epoch_len`=100, `thresh_lo`=1000, `thresh_hi`=8000, `hold_epochs`=0, occupancy 500, `sw_ack` returned 2 cycles after `sw_req`. Required: `level` steps 3→2→1→0, one step per epoch, then stays at 0; `switch_count`=3.
- Burst up: at `level`=0, drive occupancy 9000 for one cycle mid-epoch, then back to 500. Required: request to level 3 one cycle after epoch end; `level`=3 after ack; `choice_125`=1.
- Hysteresis: `hold_epochs`=3, occupancy 500. Required: step-downs are spaced by 4 epoch ends (hold expiry plus the decision epoch), not 1.
- Ack timeout: `ACK_TIMEOUT`=16, `sw_ack` tied to 0. Required: `sw_req` high for 16 cycles then drops; `ack_err`=1; `level` unchanged; `switch_count` unchanged.
- Enable drop and reset: at `level`=1, deassert `enable`. Required: `sw_req` with `sw_level`=3 on the next edge. Then assert `reset` during REQ. Required: all outputs return to their reset values on the next edge.
- Threshold edges: occupancy exactly equal to `thresh_hi` or `thresh_lo`; also `thresh_hi` < `thresh_lo` with the peak between them. Required: no change at equality; with crossed thresholds, the up-switch is chosen.

Source files
------------

// File: rtl/freq_scale_ctrl.sv
// Occupancy-driven clock-level governor: tracks the per-epoch peak queue occupancy and
// negotiates level changes with the clock mux over a req/ack handshake.
module freq_scale_ctrl #(
  parameter int EPOCH_W     = 32,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable_i,
  input  logic [31:0]        num_bytes_stay_i,
  input  logic [EPOCH_W-1:0] epoch_len_i,
  input  logic [31:0]        thresh_hi_i,
  input  logic [31:0]        thresh_lo_i,
  input  logic [3:0]         hold_epochs_i,
  output logic               sw_req_o,
  output logic [1:0]         sw_level_o,
  input  logic               sw_ack_i,
  output logic [1:0]         level_o,
  output logic               choice_50_o,
  output logic               choice_62_5_o,
  output logic               choice_83_o,
  output logic               choice_125_o,
  output logic [15:0]        switch_count_o,
  output logic               ack_err_o
);

  localparam int TO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, COMMIT} state_e;

  state_e             state_q, state_d;
  logic [EPOCH_W-1:0] ep_q, ep_d, lastEp;
  logic [31:0]        peak_q, peak_d;
  logic [3:0]         hc_q, hc_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [1:0]         level_q, level_d;
  logic [1:0]         sw_level_q, sw_level_d;
  logic [3:0]         choice_q, choice_d;
  logic               sw_req_q, sw_req_d;
  logic               ack_err_q, ack_err_d;
  logic [15:0]        count_q, count_d;
  logic               epochEnd, upHit, downHit;

  // The decision sees the peak including this cycle's sample; a zero length means one-cycle epochs.
  always_comb begin
    lastEp   = (epoch_len_i == '0) ? '0 : epoch_len_i - EPOCH_W'(1);
    epochEnd = (ep_q >= lastEp);
    ep_d     = epochEnd ? '0 : ep_q + EPOCH_W'(1);
    if ((ep_q == '0) || (num_bytes_stay_i > peak_q)) begin
      peak_d = num_bytes_stay_i;
    end else begin
      peak_d = peak_q;
    end
    upHit   = epochEnd && (peak_d > thresh_hi_i) && (level_q != 2'd3);
    downHit = epochEnd && (peak_d < thresh_lo_i) && (level_q != 2'd0) && (hc_q == 4'd0);
  end

  always_comb begin
    state_d    = state_q;
    to_d       = to_q;
    level_d    = level_q;
    sw_level_d = sw_level_q;
    choice_d   = choice_q;
    sw_req_d   = sw_req_q;
    ack_err_d  = ack_err_q;
    count_d    = count_q;
    hc_d       = (epochEnd && (hc_q != 4'd0)) ? hc_q - 4'd1 : hc_q;

    case (state_q)
      IDLE: begin
        if (!enable_i && (level_q != 2'd3)) begin
          state_d    = REQ;
          sw_req_d   = 1'b1;
          sw_level_d = 2'd3;
          to_d       = '0;
        end else if (enable_i && (upHit || downHit)) begin
          // Up-switch wins when crossed thresholds make both conditions true.
          state_d    = REQ;
          sw_req_d   = 1'b1;
          sw_level_d = upHit ? 2'd3 : level_q - 2'd1;
          to_d       = '0;
        end
      end
      REQ: begin
        if (sw_ack_i) begin
          state_d = COMMIT;
        end else if (to_q == TO_W'(ACK_TIMEOUT - 1)) begin
          state_d   = IDLE;
          sw_req_d  = 1'b0;
          ack_err_d = 1'b1;
          hc_d      = hold_epochs_i;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      COMMIT: begin
        state_d  = IDLE;
        level_d  = sw_level_q;
        choice_d = 4'b0001 << sw_level_q;
        sw_req_d = 1'b0;
        count_d  = count_q + 16'd1;
        hc_d     = hold_epochs_i;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ep_q       <= '0;
      peak_q     <= '0;
      hc_q       <= '0;
      to_q       <= '0;
      level_q    <= 2'd3;
      sw_level_q <= 2'd3;
      choice_q   <= 4'b1000;
      sw_req_q   <= 1'b0;
      ack_err_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      ep_q       <= ep_d;
      peak_q     <= peak_d;
      hc_q       <= hc_d;
      to_q       <= to_d;
      level_q    <= level_d;
      sw_level_q <= sw_level_d;
      choice_q   <= choice_d;
      sw_req_q   <= sw_req_d;
      ack_err_q  <= ack_err_d;
      count_q    <= count_d;
    end
  end

  assign sw_req_o       = sw_req_q;
  assign sw_level_o     = sw_level_q;
  assign level_o        = level_q;
  assign choice_50_o    = choice_q[0];
  assign choice_62_5_o  = choice_q[1];
  assign choice_83_o    = choice_q[2];
  assign choice_125_o   = choice_q[3];
  assign switch_count_o = count_q;
  assign ack_err_o      = ack_err_q;

endmodule

// File: tb/tb_freq_scale_ctrl.sv
// Self-checking bench for freq_scale_ctrl: a per-epoch vector table plus directed
// scale-down, burst, hysteresis, timeout, enable-drop and reset sequences.
module tb_freq_scale_ctrl;

  localparam int AckTimeout = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] numBytes;
  logic [31:0] epochLen;
  logic [31:0] threshHi;
  logic [31:0] threshLo;
  logic [3:0]  holdEpochs;
  logic        swReq;
  logic [1:0]  swLevel;
  logic        swAck;
  logic [1:0]  level;
  logic        choice50, choice625, choice83, choice125;
  logic [15:0] switchCount;
  logic        ackErr;

  int   checks    = 0;
  int   errors    = 0;
  int   reqCycles = 0;
  logic ackEnable = 1'b1;
  logic forceAck  = 1'b0;

  typedef struct {
    logic [31:0] occ;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [1:0]  expLevel;
    logic [15:0] expCount;
  } vec_t;

  vec_t vecs[13];
  logic hystReq[5];

  always #5 clk = ~clk;

  freq_scale_ctrl #(.EPOCH_W(32), .ACK_TIMEOUT(AckTimeout)) dut (
    .clk(clk), .reset(reset), .enable_i(enable), .num_bytes_stay_i(numBytes),
    .epoch_len_i(epochLen), .thresh_hi_i(threshHi), .thresh_lo_i(threshLo),
    .hold_epochs_i(holdEpochs), .sw_req_o(swReq), .sw_level_o(swLevel), .sw_ack_i(swAck),
    .level_o(level), .choice_50_o(choice50), .choice_62_5_o(choice625),
    .choice_83_o(choice83), .choice_125_o(choice125), .switch_count_o(switchCount),
    .ack_err_o(ackErr)
  );

  // The clock-mux model answers each request with a one-cycle ack two cycles after it rises.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      reqCycles = swReq ? reqCycles + 1 : 0;
      swAck     = forceAck || (ackEnable && (reqCycles == 2));
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkLevel(input string name, input logic [1:0] expLevel, input logic [15:0] expCount);
    checkOutput({name, " level"}, {30'd0, level}, {30'd0, expLevel});
    checkOutput({name, " choice"}, {28'd0, choice125, choice83, choice625, choice50}, 32'd1 << expLevel);
    checkOutput({name, " count"}, {16'd0, switchCount}, {16'd0, expCount});
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, " sw_req"}, {31'd0, swReq}, 32'd0);
    checkOutput({name, " sw_level"}, {30'd0, swLevel}, 32'd3);
    checkOutput({name, " ack_err"}, {31'd0, ackErr}, 32'd0);
    checkLevel(name, 2'd3, 16'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    numBytes = v.occ;
    threshLo = v.lo;
    threshHi = v.hi;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; numBytes = 32'd500; epochLen = 32'd8;
    threshHi = 32'd8000; threshLo = 32'd1000; holdEpochs = 4'd0; swAck = 1'b0;

    vecs[0]  = '{32'd500,        32'd1000, 32'd8000, 2'd2, 16'd1};
    vecs[1]  = '{32'd500,        32'd1000, 32'd8000, 2'd1, 16'd2};
    vecs[2]  = '{32'd1000,       32'd1000, 32'd8000, 2'd1, 16'd2};
    vecs[3]  = '{32'd8000,       32'd1000, 32'd8000, 2'd1, 16'd2};
    vecs[4]  = '{32'd3000,       32'd5000, 32'd2000, 2'd3, 16'd3};
    vecs[5]  = '{32'd3000,       32'd5000, 32'd2000, 2'd2, 16'd4};
    vecs[6]  = '{32'd4000,       32'd1000, 32'd8000, 2'd2, 16'd4};
    vecs[7]  = '{32'd999,        32'd1000, 32'd8000, 2'd1, 16'd5};
    vecs[8]  = '{32'd500,        32'd1000, 32'd8000, 2'd0, 16'd6};
    vecs[9]  = '{32'd0,          32'd1000, 32'd8000, 2'd0, 16'd6};
    vecs[10] = '{32'd8001,       32'd1000, 32'd8000, 2'd3, 16'd7};
    vecs[11] = '{32'd500,        32'd1000, 32'd8000, 2'd2, 16'd8};
    vecs[12] = '{32'hFFFF_FFFF,  32'd1000, 32'd8000, 2'd3, 16'd9};
    hystReq  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    tick(2);
    checkReset("reset");
    reset = 1'b0;

    // Rows change inputs at each epoch start and are checked four cycles after the next one.
    applyStimulus(vecs[0]);
    tick(8);
    for (int i = 0; i < 13; i++) begin
      if (i < 12) applyStimulus(vecs[i+1]);
      tick(4);
      checkLevel($sformatf("vec%0d", i), vecs[i].expLevel, vecs[i].expCount);
      checkOutput($sformatf("vec%0d sw_req", i), {31'd0, swReq}, 32'd0);
      tick(4);
    end

    reset = 1'b1; epochLen = 32'd100; numBytes = 32'd500;
    threshLo = 32'd1000; threshHi = 32'd8000; holdEpochs = 4'd0;
    tick(2);
    reset = 1'b0;
    tick(100);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("chain%0d sw_req", k), {31'd0, swReq}, 32'd1);
      checkOutput($sformatf("chain%0d sw_level", k), {30'd0, swLevel}, 32'(2 - k));
      tick(3);
      checkLevel($sformatf("chain%0d", k), 2'(2 - k), 16'(k + 1));
      tick(97);
    end
    checkOutput("chain floor sw_req", {31'd0, swReq}, 32'd0);
    checkLevel("chain floor", 2'd0, 16'd3);

    tick(50);
    numBytes = 32'd9000;
    tick(1);
    numBytes = 32'd500;
    tick(48);
    checkOutput("burst early sw_req", {31'd0, swReq}, 32'd0);
    tick(1);
    checkOutput("burst sw_req", {31'd0, swReq}, 32'd1);
    checkOutput("burst sw_level", {30'd0, swLevel}, 32'd3);
    tick(3);
    checkLevel("burst", 2'd3, 16'd4);
    holdEpochs = 4'd3;
    tick(97);

    for (int j = 0; j < 5; j++) begin
      if (j > 0) tick(100);
      checkOutput($sformatf("hyst%0d sw_req", j), {31'd0, swReq}, {31'd0, hystReq[j]});
      checkOutput($sformatf("hyst%0d level", j), {30'd0, level}, (j == 0) ? 32'd3 : 32'd2);
    end
    tick(3);
    checkLevel("hyst end", 2'd1, 16'd6);
    tick(97);

    ackEnable = 1'b0;
    numBytes  = 32'd9000;
    tick(100);
    checkOutput("timeout sw_req rise", {31'd0, swReq}, 32'd1);
    checkOutput("timeout sw_level", {30'd0, swLevel}, 32'd3);
    tick(15);
    checkOutput("timeout sw_req held", {31'd0, swReq}, 32'd1);
    tick(1);
    checkOutput("timeout sw_req drop", {31'd0, swReq}, 32'd0);
    checkOutput("timeout ack_err", {31'd0, ackErr}, 32'd1);
    checkLevel("timeout", 2'd1, 16'd6);

    enable = 1'b0;
    tick(1);
    checkOutput("enable drop sw_req", {31'd0, swReq}, 32'd1);
    checkOutput("enable drop sw_level", {30'd0, swLevel}, 32'd3);
    tick(2);
    checkOutput("enable hold sw_level", {30'd0, swLevel}, 32'd3);
    checkOutput("ack_err sticky", {31'd0, ackErr}, 32'd1);
    reset = 1'b1;
    tick(1);
    checkReset("reset in req");

    numBytes = 32'd500; epochLen = 32'd100; enable = 1'b1; ackEnable = 1'b1;
    tick(1);
    reset = 1'b0;
    forceAck = 1'b1;
    tick(3);
    checkOutput("stray ack sw_req", {31'd0, swReq}, 32'd0);
    checkLevel("stray ack", 2'd3, 16'd0);

    forceAck = 1'b0;
    epochLen = 32'd0;
    tick(1);
    checkOutput("len0 sw_req", {31'd0, swReq}, 32'd1);
    checkOutput("len0 sw_level", {30'd0, swLevel}, 32'd2);
    tick(3);
    checkLevel("len0", 2'd2, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
